panda_risc_v_wbk_arb: RTL and testbench

//  Writeback stage downstream of the iterative multiplier. Buffers multiplier results,

---
 rtl/panda_risc_v_wbk_arb_pkg.sv | 24 ++
 rtl/panda_risc_v_wbk_arb_if.sv | 34 +++
 rtl/panda_risc_v_wbk_fifo.sv | 70 +++++++
 rtl/panda_risc_v_wbk_arb.sv | 122 ++++++++++++
 tb/tb_panda_risc_v_wbk_arb.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/panda_risc_v_wbk_arb_pkg.sv
// Shared types for the writeback arbiter: request record, source select and rd decode.
package panda_risc_v_wbk_pkg;

  localparam int RF_ADDR_W  = 5;
  localparam int RF_NUM     = 32;
  localparam int WBK_DATA_W = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0]  rd;
    logic [WBK_DATA_W-1:0] data;
  } wbk_req_t;

  typedef enum logic [1:0] {
    WBK_SRC_NONE,
    WBK_SRC_ALU,
    WBK_SRC_MUL
  } wbk_src_e;

  function automatic logic [RF_NUM-1:0] rd_onehot(input logic [RF_ADDR_W-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/panda_risc_v_wbk_arb_if.sv
// Writeback bundle: MUL and ALU result inputs, register-file write port and hazard status.
interface panda_risc_v_wbk_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 2
);
  logic                  s_mul_valid;
  logic                  s_mul_ready;
  logic [4:0]            s_mul_rd;
  logic [DATA_WIDTH-1:0] s_mul_data;
  logic                  s_alu_valid;
  logic                  s_alu_ready;
  logic                  s_alu_wen;
  logic [4:0]            s_alu_rd;
  logic [DATA_WIDTH-1:0] s_alu_data;
  logic                  m_rf_wen;
  logic [4:0]            m_rf_waddr;
  logic [DATA_WIDTH-1:0] m_rf_wdata;
  logic [31:0]           pend_rd_mask;
  logic [CNT_W-1:0]      mul_buf_cnt;

  modport slave (
    input  s_mul_valid, s_mul_rd, s_mul_data,
    input  s_alu_valid, s_alu_wen, s_alu_rd, s_alu_data,
    output s_mul_ready, s_alu_ready,
    output m_rf_wen, m_rf_waddr, m_rf_wdata, pend_rd_mask, mul_buf_cnt
  );

  modport master (
    output s_mul_valid, s_mul_rd, s_mul_data,
    output s_alu_valid, s_alu_wen, s_alu_rd, s_alu_data,
    input  s_mul_ready, s_alu_ready,
    input  m_rf_wen, m_rf_waddr, m_rf_wdata, pend_rd_mask, mul_buf_cnt
  );
endinterface

// File: rtl/panda_risc_v_wbk_fifo.sv
// Synchronous FIFO for pending multiplier results; per-entry valid bits and contents are
// exposed so the parent can build the pending-rd hazard mask.
module panda_risc_v_wbk_fifo
  import panda_risc_v_wbk_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wbk_req_t
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  T                       i_push_data,
  input  logic                   i_pop,
  output T                       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_cnt,
  output logic [DEPTH-1:0]       o_ent_vld,
  output T                       o_ent [DEPTH]
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
    end else begin
      // push and pop never touch the same slot: full blocks push, empty blocks pop
      if (w_do_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

  assign o_head    = r_mem[r_rptr];
  assign o_cnt     = r_cnt;
  assign o_ent_vld = r_vld;
  assign o_ent     = r_mem;

endmodule

// File: rtl/panda_risc_v_wbk_arb.sv
// Writeback arbiter: ALU results have priority over buffered MUL results, with a
// starvation counter that forces a MUL write after STARVE_TH consecutive ALU wins.
module panda_risc_v_wbk_arb
  import panda_risc_v_wbk_pkg::*;
#(
  parameter int MUL_BUF_DEPTH = 2,
  parameter int STARVE_TH     = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  panda_risc_v_wbk_arb_if.slave       bus
);
  localparam int CNT_W = $clog2(MUL_BUF_DEPTH) + 1;

  typedef struct packed {
    logic [RF_ADDR_W-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t                     w_push_req;
  req_t                     w_head;
  req_t                     w_ent [MUL_BUF_DEPTH];
  logic [MUL_BUF_DEPTH-1:0] w_ent_vld;
  logic                     w_full;
  logic                     w_empty;
  logic [CNT_W-1:0]         w_cnt;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_force_mul;
  wbk_src_e                 w_src;
  logic [RF_NUM-1:0]        w_mask;

  logic [3:0]               r_starve;
  logic                     r_wen;
  logic [RF_ADDR_W-1:0]     r_waddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_mul_out;

  // x0 results are consumed here and never occupy a buffer slot
  assign w_push     = bus.s_mul_valid && !w_full && (bus.s_mul_rd != '0);
  assign w_push_req = '{rd: bus.s_mul_rd, data: bus.s_mul_data};

  panda_risc_v_wbk_fifo #(
    .DEPTH (MUL_BUF_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (w_push_req),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_cnt       (w_cnt),
    .o_ent_vld   (w_ent_vld),
    .o_ent       (w_ent)
  );

  always_comb begin
    w_force_mul = !w_empty && (r_starve == 4'(STARVE_TH));
    w_src       = WBK_SRC_NONE;
    if (bus.s_alu_valid && !w_force_mul) w_src = WBK_SRC_ALU;
    else if (!w_empty)                   w_src = WBK_SRC_MUL;
  end

  assign w_pop = (w_src == WBK_SRC_MUL);

  always_ff @(posedge i_clk) begin
    if (i_rst || w_empty || w_pop) begin
      r_starve <= '0;
    end else if ((w_src == WBK_SRC_ALU) && (r_starve != 4'(STARVE_TH))) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // address/data hold when nothing wins so the write port does not toggle needlessly
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_mul_out <= 1'b0;
    end else begin
      case (w_src)
        WBK_SRC_ALU: begin
          r_wen     <= bus.s_alu_wen && (bus.s_alu_rd != '0);
          r_waddr   <= bus.s_alu_rd;
          r_wdata   <= bus.s_alu_data;
          r_mul_out <= 1'b0;
        end
        WBK_SRC_MUL: begin
          r_wen     <= 1'b1;
          r_waddr   <= w_head.rd;
          r_wdata   <= w_head.data;
          r_mul_out <= 1'b1;
        end
        default: begin
          r_wen     <= 1'b0;
          r_mul_out <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_mask = r_mul_out ? rd_onehot(r_waddr) : '0;
    for (int i = 0; i < MUL_BUF_DEPTH; i++) begin
      if (w_ent_vld[i]) w_mask = w_mask | rd_onehot(w_ent[i].rd);
    end
  end

  assign bus.s_mul_ready  = !w_full;
  assign bus.s_alu_ready  = !w_force_mul;
  assign bus.m_rf_wen     = r_wen;
  assign bus.m_rf_waddr   = r_waddr;
  assign bus.m_rf_wdata   = r_wdata;
  assign bus.pend_rd_mask = w_mask;
  assign bus.mul_buf_cnt  = w_cnt;

endmodule

// File: tb/tb_panda_risc_v_wbk_arb.sv
// Bench for the writeback arbiter: directed scenarios plus random traffic, all compared
// cycle by cycle against a queue-based model of the arbitration rules.
module tb_panda_risc_v_wbk_arb;
  localparam int DEPTH = 2;
  localparam int TH    = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  panda_risc_v_wbk_arb_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  panda_risc_v_wbk_arb #(
    .MUL_BUF_DEPTH (DEPTH),
    .STARVE_TH     (TH),
    .DATA_WIDTH    (DW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  int            starve;
  logic          m_wen;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_mul_out;
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit mv, input logic [4:0] mrd, input logic [DW-1:0] md,
                       input bit av, input bit aw, input logic [4:0] ard, input logic [DW-1:0] ad);
    bus.s_mul_valid = mv;
    bus.s_mul_rd    = mrd;
    bus.s_mul_data  = md;
    bus.s_alu_valid = av;
    bus.s_alu_wen   = aw;
    bus.s_alu_rd    = ard;
    bus.s_alu_data  = ad;
  endtask

  task automatic model_reset();
    mq.delete();
    starve    = 0;
    m_wen     = 1'b0;
    m_waddr   = '0;
    m_wdata   = '0;
    m_mul_out = 1'b0;
  endtask

  function automatic logic [31:0] exp_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (m_mul_out) m[m_waddr] = 1'b1;
    return m;
  endfunction

  task automatic check_outputs(input string pfx);
    chk({pfx, "_wen"},   bus.m_rf_wen,     m_wen);
    chk({pfx, "_waddr"}, bus.m_rf_waddr,   m_waddr);
    chk({pfx, "_wdata"}, bus.m_rf_wdata,   m_wdata);
    chk({pfx, "_mask"},  bus.pend_rd_mask, exp_mask());
    chk({pfx, "_cnt"},   bus.mul_buf_cnt,  mq.size());
  endtask

  // Entered just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(output bit acc);
    int   sz;
    bit   force_mul, alu_win, pop;
    ent_t e;
    #1;
    sz        = mq.size();
    force_mul = (sz != 0) && (starve == TH);
    chk("mul_ready", bus.s_mul_ready, (sz < DEPTH));
    chk("alu_ready", bus.s_alu_ready, !force_mul);
    alu_win = bus.s_alu_valid && !force_mul;
    pop     = !alu_win && (sz != 0);
    acc     = bus.s_mul_valid && (sz < DEPTH);
    if (sz == 0 || pop)               starve = 0;
    else if (alu_win && starve < TH)  starve = starve + 1;
    if (alu_win) begin
      m_wen     = bus.s_alu_wen && (bus.s_alu_rd != 0);
      m_waddr   = bus.s_alu_rd;
      m_wdata   = bus.s_alu_data;
      m_mul_out = 1'b0;
    end else if (pop) begin
      e         = mq.pop_front();
      m_wen     = 1'b1;
      m_waddr   = e.rd;
      m_wdata   = e.data;
      m_mul_out = 1'b1;
    end else begin
      m_wen     = 1'b0;
      m_mul_out = 1'b0;
    end
    if (acc && bus.s_mul_rd != 0) mq.push_back('{rd: bus.s_mul_rd, data: bus.s_mul_data});
    @(posedge clk);
    #1;
    check_outputs("step");
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step(acc);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit         acc, found, saw_full;
    int         n, pidx;
    logic [4:0] order[$];
    logic [4:0] prd [3];

    model_reset();
    do_reset();
    idle(2);

    // 1: ALU only, back to back
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1, 5'(i + 1), 32'(8'h11 * (i + 1)));
      step(acc);
      chk("t1_wen", bus.m_rf_wen, 1);
      chk("t1_waddr", bus.m_rf_waddr, i + 1);
      chk("t1_wdata", bus.m_rf_wdata, 8'h11 * (i + 1));
    end
    idle(2);

    // 2: single MUL result, two-cycle latency and mask lifetime
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(acc);
    chk("t2_mask_n1", bus.pend_rd_mask[5], 1);
    chk("t2_wen_n1", bus.m_rf_wen, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(acc);
    chk("t2_wen_n2", bus.m_rf_wen, 1);
    chk("t2_waddr_n2", bus.m_rf_waddr, 5);
    chk("t2_wdata_n2", bus.m_rf_wdata, 32'hDEADBEEF);
    chk("t2_mask_n2", bus.pend_rd_mask[5], 1);
    step(acc);
    chk("t2_mask_n3", bus.pend_rd_mask[5], 0);
    idle(1);

    // 3: starvation forces x7 out after TH consecutive ALU wins
    drive(1, 7, 32'h7777, 1, 1, 1, 32'h100);
    step(acc);
    n = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      drive(0, 0, 0, 1, 1, 5'(2 + (k % 4)), 32'h200 + k);
      step(acc);
      if (bus.m_rf_wen && bus.m_rf_waddr == 7) found = 1;
      else if (bus.m_rf_wen) n++;
    end
    chk("t3_mul_written", found, 1);
    chk("t3_alu_wins_before_mul", n, TH);
    drive(0, 0, 0, 1, 1, 3, 32'h333);
    step(acc);
    chk("t3_alu_resumes", bus.m_rf_waddr, 3);
    idle(2);

    // 4: fill the buffer under ALU pressure; third push waits, order preserved
    prd[0] = 8; prd[1] = 9; prd[2] = 10;
    pidx = 0;
    saw_full = 0;
    for (int k = 0; k < 40 && order.size() < 3; k++) begin
      if (pidx < 3) drive(1, prd[pidx], 32'hA000 + pidx, 1, 1, 5'(1 + (k % 3)), 32'h300 + k);
      else          drive(0, 0, 0, 1, 1, 5'(1 + (k % 3)), 32'h300 + k);
      step(acc);
      if (acc && pidx < 3) pidx++;
      if (bus.m_rf_wen && bus.m_rf_waddr >= 8 && bus.m_rf_waddr <= 10) order.push_back(bus.m_rf_waddr);
      if (pidx == 2 && mq.size() == DEPTH && !saw_full) begin
        saw_full = 1;
        chk("t4_ready_when_full", bus.s_mul_ready, 0);
      end
    end
    chk("t4_full_seen", saw_full, 1);
    chk("t4_writes", order.size(), 3);
    for (int i = 0; i < 3; i++) chk("t4_order", (i < order.size()) ? order[i] : 5'd0, prd[i]);
    idle(2);

    // 5: x0 destinations are consumed without a write
    drive(1, 0, 32'h1234, 1, 1, 0, 32'h5678);
    step(acc);
    chk("t5_accepted", acc, 1);
    chk("t5_wen", bus.m_rf_wen, 0);
    idle(1);
    chk("t5_wen_late", bus.m_rf_wen, 0);
    chk("t5_mask", bus.pend_rd_mask, 0);

    // 6: reset with two buffered entries discards them
    drive(1, 12, 32'hC0C0, 1, 1, 1, 32'h1);
    step(acc);
    drive(1, 13, 32'hD0D0, 1, 1, 2, 32'h2);
    step(acc);
    chk("t6_cnt_before", bus.mul_buf_cnt, 2);
    do_reset();
    chk("t6_mask", bus.pend_rd_mask, 0);
    chk("t6_cnt", bus.mul_buf_cnt, 0);
    found = 0;
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step(acc);
      if (bus.m_rf_wen) found = 1;
    end
    chk("t6_no_stale_write", found, 0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 1) == 1,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) != 0,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom);
        step(acc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
